// File: rtl/ram_sdp_pipe.sv
// Simple dual-port RAM with byte enables, a RD_LATENCY-deep read pipeline and an optional post-reset zero sweep.
// Read data is valid RD_LATENCY-1 edges after the accepting edge; there is no backpressure, only ready low during the sweep.
module ram_sdp_pipe #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic [ADDR_WIDTH-1:0]   o_rd_addr_out,
  output logic                    o_rd_valid,
  output logic                    o_ready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % 8) != 0 || RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_param_err
    $error("ram_sdp_pipe: DATA_WIDTH must be a multiple of 8 and RD_LATENCY must be 1..4");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_run;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [NB-1:0]           w_mem_be;
  logic [DATA_WIDTH-1:0]   w_mem_wdat;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  logic                    r_pvld [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   r_pdat [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]   r_padr [RD_LATENCY];

  assign w_run    = (r_state == ST_RUN);
  assign w_wr_acc = w_run && i_wr_en;
  assign w_rd_acc = w_run && i_rd_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = r_state;
    endcase
  end

  // The sweep borrows the single write port; user writes are ignored until it finishes.
  always_comb begin
    w_mem_we   = w_wr_acc;
    w_mem_addr = i_wr_addr;
    w_mem_be   = i_wr_be;
    w_mem_wdat = i_wr_data;
    if (r_state == ST_INIT) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_cnt;
      w_mem_be   = '1;
      w_mem_wdat = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_mem_we && w_mem_be[b]) begin
        r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdat[8*b +: 8];
      end
    end
  end

  // Write-first bypass merges only the enabled lanes over the old word.
  always_comb begin
    w_rd_word = r_mem[i_rd_addr];
    if (RDW_MODE == 1 && w_wr_acc && (i_wr_addr == i_rd_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wr_be[b]) w_rd_word[8*b +: 8] = i_wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pvld[i] <= 1'b0;
        r_pdat[i] <= '0;
        r_padr[i] <= '0;
      end
    end else begin
      r_pvld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_pdat[0] <= w_rd_word;
        r_padr[0] <= i_rd_addr;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pvld[i] <= r_pvld[i-1];
        if (r_pvld[i-1]) begin
          r_pdat[i] <= r_pdat[i-1];
          r_padr[i] <= r_padr[i-1];
        end
      end
    end
  end

  assign o_rd_valid    = r_pvld[RD_LATENCY-1];
  assign o_rd_data     = r_pdat[RD_LATENCY-1];
  assign o_rd_addr_out = r_padr[RD_LATENCY-1];
  assign o_ready       = w_run;

endmodule

// File: tb/tb_ram_sdp_pipe.sv
// Directed bench: two 16-bit/16-deep instances (latency 3 read-first, latency 2 write-first) share stimulus,
// plus an 8-bit latency-1 instance without the clear sweep driven separately.
module tb_ram_sdp_pipe;

  logic        clk;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic [15:0] d0, d1;
  logic [3:0]  a0, a1;
  logic        v0, v1, rdy0, rdy1;

  logic        c_wr_en, c_rd_en;
  logic [2:0]  c_wr_addr, c_rd_addr;
  logic [0:0]  c_wr_be;
  logic [7:0]  c_wr_data;
  logic [7:0]  d2;
  logic [2:0]  a2;
  logic        v2, rdy2;

  ram_sdp_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(3), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_be(wr_be),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(d0),
    .o_rd_addr_out(a0), .o_rd_valid(v0), .o_ready(rdy0));

  ram_sdp_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_be(wr_be),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(d1),
    .o_rd_addr_out(a1), .o_rd_valid(v1), .o_ready(rdy1));

  ram_sdp_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(c_wr_en), .i_wr_addr(c_wr_addr), .i_wr_be(c_wr_be),
    .i_wr_data(c_wr_data), .i_rd_en(c_rd_en), .i_rd_addr(c_rd_addr), .o_rd_data(d2),
    .o_rd_addr_out(a2), .o_rd_valid(v2), .o_ready(rdy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Issued reads indexed by step number, with the expected word for each instance.
  logic        hv [512];
  logic [3:0]  ha [512];
  logic [15:0] h0 [512];
  logic [15:0] h1 [512];
  int          s = 0;
  int          hstart = 0;
  bit          run = 0;
  int          sweep = 0;
  logic [15:0] held0_d = '0, held1_d = '0;
  logic [3:0]  held0_a = '0, held1_a = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (step %0d, t=%0t)", nm, act, exp, s, $time);
    end
  endtask

  task automatic step(input logic we, input logic [3:0] wa, input logic [1:0] be, input logic [15:0] wd,
                      input logic re, input logic [3:0] ra, input logic [15:0] e0, input logic [15:0] e1);
    logic ev;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra;
    hv[s] = re && run; ha[s] = ra; h0[s] = e0; h1[s] = e1;
    @(posedge clk); #1;
    if (!run) begin
      sweep++;
      if (sweep == 16) run = 1;
    end
    chk("ready0", {31'b0, rdy0}, {31'b0, run});
    chk("ready1", {31'b0, rdy1}, {31'b0, run});
    ev = (s - 2 >= hstart) && hv[s-2];
    if (ev) begin held0_d = h0[s-2]; held0_a = ha[s-2]; end
    chk("valid0", {31'b0, v0}, {31'b0, ev});
    chk("data0", {16'b0, d0}, {16'b0, held0_d});
    chk("addr0", {28'b0, a0}, {28'b0, held0_a});
    ev = (s - 1 >= hstart) && hv[s-1];
    if (ev) begin held1_d = h1[s-1]; held1_a = ha[s-1]; end
    chk("valid1", {31'b0, v1}, {31'b0, ev});
    chk("data1", {16'b0, d1}, {16'b0, held1_d});
    chk("addr1", {28'b0, a1}, {28'b0, held1_a});
    s++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    wr_en = 0; rd_en = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid0", {31'b0, v0}, 0);
    chk("rst_valid1", {31'b0, v1}, 0);
    chk("rst_data0", {16'b0, d0}, 0);
    chk("rst_data1", {16'b0, d1}, 0);
    chk("rst_addr1", {28'b0, a1}, 0);
    chk("rst_ready0", {31'b0, rdy0}, 0);
    chk("rst_ready1", {31'b0, rdy1}, 0);
    chk("rst_ready2", {31'b0, rdy2}, 1);
    chk("rst_valid2", {31'b0, v2}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    hstart = s; run = 0; sweep = 0;
    held0_d = '0; held1_d = '0; held0_a = '0; held1_a = '0;
  endtask

  task automatic c_step(input logic we, input logic [2:0] wa, input logic be, input logic [7:0] wd,
                        input logic re, input logic [2:0] ra,
                        input logic ev, input logic [7:0] ed, input logic [2:0] ea);
    c_wr_en = we; c_wr_addr = wa; c_wr_be = be; c_wr_data = wd;
    c_rd_en = re; c_rd_addr = ra;
    @(posedge clk); #1;
    chk("u2_ready", {31'b0, rdy2}, 1);
    chk("u2_valid", {31'b0, v2}, {31'b0, ev});
    chk("u2_data", {24'b0, d2}, {24'b0, ed});
    chk("u2_addr", {29'b0, a2}, {29'b0, ea});
  endtask

  vec_t tbl [19];

  initial begin
    tbl[0]  = '{1, 3, 2'b11, 16'h00A5, 0, 0, 16'h0000, 16'h0000};
    tbl[1]  = '{0, 0, 2'b00, 16'h0000, 1, 3, 16'h00A5, 16'h00A5};
    tbl[2]  = '{0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    tbl[3]  = '{0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    tbl[4]  = '{0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    tbl[5]  = '{1, 5, 2'b11, 16'h1234, 0, 0, 16'h0000, 16'h0000};
    tbl[6]  = '{1, 5, 2'b01, 16'hABCD, 0, 0, 16'h0000, 16'h0000};
    tbl[7]  = '{0, 0, 2'b00, 16'h0000, 1, 5, 16'h12CD, 16'h12CD};
    tbl[8]  = '{1, 7, 2'b11, 16'h0011, 0, 0, 16'h0000, 16'h0000};
    tbl[9]  = '{1, 7, 2'b11, 16'h0022, 1, 7, 16'h0011, 16'h0022};
    tbl[10] = '{0, 0, 2'b00, 16'h0000, 1, 7, 16'h0022, 16'h0022};
    tbl[11] = '{1, 7, 2'b10, 16'h3344, 1, 7, 16'h0022, 16'h3322};
    tbl[12] = '{0, 0, 2'b00, 16'h0000, 1, 7, 16'h3322, 16'h3322};
    tbl[13] = '{1, 8, 2'b11, 16'h5555, 1, 9, 16'h0000, 16'h0000};
    tbl[14] = '{0, 0, 2'b00, 16'h0000, 1, 8, 16'h5555, 16'h5555};
    tbl[15] = '{1, 3, 2'b00, 16'hFFFF, 1, 3, 16'h00A5, 16'h00A5};
    tbl[16] = '{0, 0, 2'b00, 16'h0000, 1, 3, 16'h00A5, 16'h00A5};
    tbl[17] = '{0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    tbl[18] = '{0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 16'h0000};

    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
    c_wr_en = 0; c_wr_addr = 0; c_wr_be = 0; c_wr_data = 0; c_rd_en = 0; c_rd_addr = 0;
    #12;
    chk("init_valid0", {31'b0, v0}, 0);
    chk("init_valid1", {31'b0, v1}, 0);
    chk("init_data0", {16'b0, d0}, 0);
    chk("init_addr0", {28'b0, a0}, 0);
    chk("init_ready0", {31'b0, rdy0}, 0);
    chk("init_ready1", {31'b0, rdy1}, 0);
    chk("init_ready2", {31'b0, rdy2}, 1);
    chk("init_valid2", {31'b0, v2}, 0);
    chk("init_data2", {24'b0, d2}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sweep: reads and all-ones writes are offered every edge and must be ignored.
    for (int k = 0; k < 16; k++) step(1, 4'(k), 2'b11, 16'hFFFF, 1, 4'(k), 0, 0);
    // Back-to-back reads of the whole array: all cleared, addresses in order.
    for (int k = 0; k < 16; k++) step(0, 0, 0, 0, 1, 4'(k), 0, 0);
    idle(3);

    for (int i = 0; i < 19; i++)
      step(tbl[i].we, tbl[i].wa, tbl[i].be, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].e0, tbl[i].e1);

    // Reset with two reads in flight, then a second reset part-way through the sweep.
    step(0, 0, 0, 0, 1, 3, 16'h00A5, 16'h00A5);
    step(0, 0, 0, 0, 1, 5, 16'h12CD, 16'h12CD);
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 2, 2'b11, 16'hFFFF, 1, 2, 0, 0);
    do_reset();
    for (int k = 0; k < 16; k++) step(1, 2, 2'b11, 16'hFFFF, 1, 2, 0, 0);
    step(0, 0, 0, 0, 1, 2, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 0);
    idle(3);

    // Latency-1 instance without sweep; output registers were reset by the last reset.
    c_step(1, 6, 1, 8'h5A, 0, 0, 0, 8'h00, 0);
    c_step(1, 6, 1, 8'h77, 1, 6, 1, 8'h5A, 6);
    c_step(0, 0, 0, 8'h00, 1, 6, 1, 8'h77, 6);
    c_step(0, 0, 0, 8'h00, 0, 0, 0, 8'h77, 6);
    c_step(1, 1, 1, 8'h3C, 0, 0, 0, 8'h77, 6);
    c_step(1, 1, 0, 8'hFF, 1, 1, 1, 8'h3C, 1);
    c_step(0, 0, 0, 8'h00, 1, 1, 1, 8'h3C, 1);
    c_step(0, 0, 0, 8'h00, 0, 0, 0, 8'h3C, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
